// File: rtl/key_event_fifo.sv
// Keypad event FIFO: accepts scanner key events, suppresses repeats of the
// same code within a lockout window, and queues accepted codes for a consumer.
module key_event_fifo #(
  parameter int DEPTH   = 8,
  parameter int LOCKOUT = 1000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               Code,
  input  logic                     Valid,
  output logic [3:0]               out_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LOCKOUT + 1);

  logic [3:0]    storage [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [3:0]    lastCode_q, lastCode_d;
  logic          lastVld_q, lastVld_d;
  logic [LW-1:0] lockCnt_q, lockCnt_d;

  logic suppress, accept, pop, push, drop, isFull, isEmpty;

  assign isEmpty  = (count_q == '0);
  assign isFull   = (count_q == CW'(DEPTH));
  assign suppress = lastVld_q && (lockCnt_q != '0) && (Code == lastCode_q);
  assign accept   = Valid && !suppress;
  assign pop      = !isEmpty && out_ready;
  assign push     = accept && (!isFull || pop);
  assign drop     = accept && isFull && !pop;

  // Dropped events still refresh the repeat filter, so the lockout window is
  // driven purely by what the scanner reported, not by FIFO occupancy.
  always_comb begin
    lastCode_d = lastCode_q;
    lastVld_d  = lastVld_q;
    lockCnt_d  = lockCnt_q;
    if (accept) begin
      lastCode_d = Code;
      lastVld_d  = 1'b1;
      lockCnt_d  = LW'(LOCKOUT);
    end else if (lockCnt_q != '0) begin
      lockCnt_d = lockCnt_q - LW'(1);
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear request wins.
    if (drop)
      overflow_d = 1'b1;
    else if (clear_overflow)
      overflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      lastCode_q <= 4'h0;
      lastVld_q  <= 1'b0;
      lockCnt_q  <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      lastCode_q <= lastCode_d;
      lastVld_q  <= lastVld_d;
      lockCnt_q  <= lockCnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push)
      storage[wrPtr_q] <= Code;
  end

  assign out_valid = !isEmpty;
  assign out_code  = isEmpty ? 4'h0 : storage[rdPtr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two and at least 2.
REQ-002 Parameter LOCKOUT, default 1000, repeat-suppression window in clock cycles; SHALL be at least 1.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 Code  input  4  key code from the keypad scanner, meaningful only while Valid=1.
REQ-006 Valid  input  1  key-event qualifier from the scanner, sampled every cycle.
REQ-007 out_code  output  4  key code at the FIFO head.
REQ-008 out_valid  output  1  FIFO non-empty; out_code is meaningful.
REQ-009 out_ready  input  1  consumer accepts the head entry this cycle.
REQ-010 count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-011 overflow  output  1  sticky flag: at least one accepted event was lost because the FIFO was full.
REQ-012 clear_overflow  input  1  clears overflow.

Function
REQ-013 Event candidate: any cycle with Valid=1.
REQ-014 Internal state: last_code (4b), last_vld (1b), lockout counter (wide enough for LOCKOUT).
REQ-015 A candidate SHALL be suppressed when last_vld=1, the lockout counter is non-zero, and Code equals last_code; otherwise it is accepted.
REQ-016 A candidate whose Code differs from last_code SHALL be accepted even while the lockout counter is non-zero.
REQ-017 On accept: last_code<=Code, last_vld<=1, lockout counter<=LOCKOUT.
REQ-018 When there is no accept, a non-zero lockout counter SHALL decrement by 1 per cycle and SHALL saturate at 0.
REQ-019 Suppressed candidates SHALL NOT change last_code, last_vld, the lockout counter, the FIFO, or overflow.
REQ-020 Push: an accepted event SHALL be written at the write pointer when count<DEPTH or when a pop occurs in the same cycle.
REQ-021 Pop: a pop SHALL occur when out_valid=1 and out_ready=1; the read pointer then advances.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 count SHALL be: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-024 out_valid SHALL equal (count!=0).
REQ-025 out_code SHALL equal the storage entry at the read pointer when count!=0, and 4'h0 when count=0.
REQ-026 Latency: an event accepted in cycle N SHALL appear on out_valid/out_code in cycle N+1 if the FIFO was empty; there SHALL be no combinational bypass from Code to out_code.
REQ-027 Full-FIFO drop: an accepted event with count=DEPTH and no same-cycle pop SHALL be dropped, SHALL set overflow, and SHALL still update last_code and the lockout counter.
REQ-028 overflow SHALL be cleared by clear_overflow=1; if a drop and clear_overflow occur in the same cycle, set SHALL win.
REQ-029 out_ready with count=0 SHALL have no effect.

Reset
REQ-030 On reset=1 at a clock edge: both pointers=0, count=0, out_valid=0, out_code=4'h0, overflow=0, last_vld=0, last_code=4'h0, lockout counter=0; storage contents need not be cleared.
REQ-031 Reset SHALL take priority over all same-cycle push, pop and clear activity; inputs in the reset cycle SHALL be ignored.
REQ-032 The first Valid after reset SHALL always be accepted.

Verification (LOCKOUT=4, DEPTH=8 for the bench)
REQ-033 Reset, then Valid=1 with Code=5 for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_code=5, count=1.
REQ-034 Code=5 accepted, then Code=5 Valid pulses 2 and 4 cycles later -> both suppressed, count=1; a Code=5 pulse 6 cycles after the accept -> accepted, count=2.
REQ-035 Code=5 accepted, Code=9 on the next cycle -> accepted, count=2, pop order 5 then 9.
REQ-036 Fill with 8 distinct codes (out_ready=0), then a 9th new code -> count stays 8, overflow=1; the same event with out_ready=1 -> pushed, count stays 8, overflow unchanged.
REQ-037 overflow=1, then clear_overflow=1 in the same cycle as another full drop -> overflow stays 1; clear_overflow alone next cycle -> overflow=0.
REQ-038 FIFO holding 3 entries with a reset pulse while Valid=1 -> next cycle count=0, out_valid=0, out_code=0, overflow=0; the following Valid (any code) is accepted.
